// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control FSM.
// Sequences fetch/decode/exec/memory/writeback and drives the datapath control bus.
module mc_ctrl_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [19:0] ctrl_word,
    output logic [25:0] imm26,
    output logic [2:0]  state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEMACC = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam int REG_DST   = 0;
    localparam int ALU_SRC_B = 1;
    localparam int MEM_TO_RG = 2;
    localparam int REG_WRITE = 3;
    localparam int MEM_READ  = 4;
    localparam int MEM_WRITE = 5;
    localparam int BRANCH    = 6;
    localparam int PC_WRITE  = 10;
    localparam int IR_WRITE  = 11;
    localparam int I_OR_D    = 12;
    localparam int ALU_SRC_A = 13;
    localparam int SIGN_EXT  = 14;
    localparam int JUMP      = 15;
    localparam int LINK      = 16;
    localparam int JR        = 17;
    localparam int ILLEGAL   = 18;
    localparam int RETIRE    = 19;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [2:0]  state_nxt;
    logic [19:0] cw;

    logic is_r, is_jr, r_alu, is_lw, is_sw;
    logic is_beq, is_addi, is_j, is_jal;

    assign is_r    = (opcode == OP_R);
    assign is_jr   = is_r && (funct == FN_JR);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_addi = (opcode == OP_ADDI);
    assign is_j    = (opcode == OP_J);
    assign is_jal  = (opcode == OP_JAL);

    // Supported R-type ALU functs: add/u, sub/u, and, or, xor, nor, slt/u
    always_comb begin
        r_alu = 1'b0;
        case (funct)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110, 6'b100111,
            6'b101010, 6'b101011: r_alu = is_r;
            default:              r_alu = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cw        = '0;
        case (state)
            S_FETCH: begin
                cw[MEM_READ] = 1'b1;
                if (mem_ready) begin
                    cw[IR_WRITE] = 1'b1;
                    cw[PC_WRITE] = 1'b1;
                    state_nxt    = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_j: begin
                        cw[JUMP]     = 1'b1;
                        cw[PC_WRITE] = 1'b1;
                        cw[RETIRE]   = 1'b1;
                        state_nxt    = S_FETCH;
                    end
                    is_jal: begin
                        cw[JUMP]      = 1'b1;
                        cw[LINK]      = 1'b1;
                        cw[REG_WRITE] = 1'b1;
                        cw[PC_WRITE]  = 1'b1;
                        cw[RETIRE]    = 1'b1;
                        state_nxt     = S_FETCH;
                    end
                    is_jr: begin
                        cw[JR]       = 1'b1;
                        cw[PC_WRITE] = 1'b1;
                        cw[RETIRE]   = 1'b1;
                        state_nxt    = S_FETCH;
                    end
                    r_alu, is_lw, is_sw, is_beq, is_addi: begin
                        cw[SIGN_EXT] = 1'b1;
                        state_nxt    = S_EXEC;
                    end
                    default: state_nxt = S_TRAP;
                endcase
            end
            S_EXEC: begin
                cw[ALU_SRC_A] = 1'b1;
                unique case (1'b1)
                    is_r: begin
                        cw[9:7]   = 3'b010;
                        state_nxt = S_WB;
                    end
                    is_addi, is_lw, is_sw: begin
                        cw[ALU_SRC_B] = 1'b1;
                        cw[SIGN_EXT]  = 1'b1;
                        state_nxt     = is_addi ? S_WB : S_MEMACC;
                    end
                    is_beq: begin
                        cw[9:7]    = 3'b001;
                        cw[BRANCH] = 1'b1;
                        cw[RETIRE] = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                    default: state_nxt = S_TRAP;
                endcase
            end
            S_MEMACC: begin
                cw[I_OR_D]    = 1'b1;
                cw[MEM_READ]  = is_lw;
                cw[MEM_WRITE] = is_sw;
                if (mem_ready) begin
                    if (is_lw) begin
                        state_nxt = S_WB;
                    end else begin
                        cw[RETIRE] = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                end
            end
            S_WB: begin
                cw[REG_WRITE] = 1'b1;
                cw[RETIRE]    = 1'b1;
                cw[MEM_TO_RG] = is_lw;
                cw[REG_DST]   = is_r;
                state_nxt     = S_FETCH;
            end
            S_TRAP: cw[ILLEGAL] = 1'b1;
            default: state_nxt = S_TRAP;
        endcase
    end

    assign ctrl_word = rst_n ? cw : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            opcode <= '0;
            funct  <= '0;
            imm26  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && mem_ready) begin
                opcode <= mem_rdata[31:26];
                funct  <= mem_rdata[5:0];
                imm26  <= mem_rdata[25:0];
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm: per-cycle expectations queued
// alongside the stimulus, then popped and compared each cycle.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [19:0] ctrl_word;
    logic [25:0] imm26;
    logic [2:0]  state;

    mc_ctrl_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .ctrl_word (ctrl_word),
        .imm26     (imm26),
        .state     (state)
    );

    always #5 clk = ~clk;

    localparam logic [19:0] RD  = 20'h00001;
    localparam logic [19:0] ASB = 20'h00002;
    localparam logic [19:0] MTR = 20'h00004;
    localparam logic [19:0] RW  = 20'h00008;
    localparam logic [19:0] MR  = 20'h00010;
    localparam logic [19:0] MW  = 20'h00020;
    localparam logic [19:0] BR  = 20'h00040;
    localparam logic [19:0] OP1 = 20'h00080;
    localparam logic [19:0] OP2 = 20'h00100;
    localparam logic [19:0] PCW = 20'h00400;
    localparam logic [19:0] IRW = 20'h00800;
    localparam logic [19:0] IOD = 20'h01000;
    localparam logic [19:0] ASA = 20'h02000;
    localparam logic [19:0] SE  = 20'h04000;
    localparam logic [19:0] JMP = 20'h08000;
    localparam logic [19:0] LNK = 20'h10000;
    localparam logic [19:0] JRB = 20'h20000;
    localparam logic [19:0] ILL = 20'h40000;
    localparam logic [19:0] RET = 20'h80000;
    localparam logic [19:0] FET = MR | PCW | IRW;

    localparam logic [2:0] SF = 3'd0;
    localparam logic [2:0] SD = 3'd1;
    localparam logic [2:0] SE_ = 3'd2;
    localparam logic [2:0] SM = 3'd3;
    localparam logic [2:0] SW = 3'd4;
    localparam logic [2:0] ST = 3'd5;

    typedef struct packed {
        logic        rst;
        logic        mr;
        logic [31:0] rd;
        logic [2:0]  st;
        logic [19:0] cw;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [2:0]  s;
    logic [19:0] c;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_ret = 0;
    int          r0;

    function automatic void push(logic r, logic m, logic [31:0] d,
                                 logic [2:0] st, logic [19:0] cw);
        sb.push_back({r, m, d, st, cw});
    endfunction

    task automatic step(input exp_t x, output logic [2:0] so,
                        output logic [19:0] co);
        @(negedge clk);
        rst_n     = x.rst;
        mem_ready = x.mr;
        mem_rdata = x.rd;
        #1;
        so = state;
        co = ctrl_word;
        if (co[19]) n_ret++;
    endtask

    task automatic test_reset;
        push(0, 0, 32'h08000010, SF, 20'h0);
        push(0, 1, 32'h08000010, SF, 20'h0);
        push(0, 0, 32'h08000010, SF, 20'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(e, s, c);
            n_cmp++;
            if (s !== e.st || c !== e.cw) begin
                n_err++;
                $display("FAIL reset: state=%0d cw=%h required state=%0d cw=%h",
                         s, c, e.st, e.cw);
            end
        end
        n_cmp++;
        if (imm26 !== 26'h0) begin
            n_err++;
            $display("FAIL reset_imm: imm26=%h required 0", imm26);
        end
    endtask

    task automatic test_jump;
        logic [31:0] d = 32'h08000010;
        r0 = n_ret;
        push(1, 1, d, SF, FET);
        push(1, 1, d, SD, JMP | PCW | RET);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(e, s, c);
            n_cmp++;
            if (s !== e.st || c !== e.cw) begin
                n_err++;
                $display("FAIL jump: state=%0d cw=%h required state=%0d cw=%h",
                         s, c, e.st, e.cw);
            end
        end
        n_cmp++;
        if (imm26 !== 26'h0000010 || n_ret - r0 != 1) begin
            n_err++;
            $display("FAIL jump_imm: imm26=%h retires=%0d required 0000010 / 1",
                     imm26, n_ret - r0);
        end
    endtask

    task automatic test_lw_wait;
        logic [31:0] d = 32'h8C220004;
        r0 = n_ret;
        push(1, 0, d, SF, MR);
        push(1, 1, d, SF, FET);
        push(1, 1, d, SD, SE);
        push(1, 1, d, SE_, ASA | ASB | SE);
        push(1, 0, d, SM, IOD | MR);
        push(1, 0, d, SM, IOD | MR);
        push(1, 1, d, SM, IOD | MR);
        push(1, 1, d, SW, RW | RET | MTR);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(e, s, c);
            n_cmp++;
            if (s !== e.st || c !== e.cw) begin
                n_err++;
                $display("FAIL lw_wait: state=%0d cw=%h required state=%0d cw=%h",
                         s, c, e.st, e.cw);
            end
        end
        n_cmp++;
        if (n_ret - r0 != 1) begin
            n_err++;
            $display("FAIL lw_retire: retires=%0d required 1", n_ret - r0);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        r0 = n_ret;
        d = 32'h00221820;
        push(1, 1, d, SF, FET);
        push(1, 1, d, SD, SE);
        push(1, 1, d, SE_, ASA | OP2);
        push(1, 1, d, SW, RW | RET | RD);
        d = 32'h03E00008;
        push(1, 1, d, SF, FET);
        push(1, 1, d, SD, JRB | PCW | RET);
        d = 32'h10220003;
        push(1, 1, d, SF, FET);
        push(1, 1, d, SD, SE);
        push(1, 1, d, SE_, ASA | OP1 | BR | RET);
        d = 32'h20220005;
        push(1, 1, d, SF, FET);
        push(1, 1, d, SD, SE);
        push(1, 1, d, SE_, ASA | ASB | SE);
        push(1, 1, d, SW, RW | RET);
        d = 32'hAC220000;
        push(1, 1, d, SF, FET);
        push(1, 1, d, SD, SE);
        push(1, 1, d, SE_, ASA | ASB | SE);
        push(1, 1, d, SM, IOD | MW | RET);
        d = 32'h0C000100;
        push(1, 1, d, SF, FET);
        push(1, 1, d, SD, JMP | LNK | RW | PCW | RET);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(e, s, c);
            n_cmp++;
            if (s !== e.st || c !== e.cw) begin
                n_err++;
                $display("FAIL b2b: state=%0d cw=%h required state=%0d cw=%h",
                         s, c, e.st, e.cw);
            end
        end
        n_cmp++;
        if (imm26 !== 26'h0000100 || n_ret - r0 != 6) begin
            n_err++;
            $display("FAIL b2b_end: imm26=%h retires=%0d required 0000100 / 6",
                     imm26, n_ret - r0);
        end
    endtask

    task automatic test_sw_reset;
        logic [31:0] d = 32'hAC220000;
        r0 = n_ret;
        push(1, 1, d, SF, FET);
        push(1, 1, d, SD, SE);
        push(1, 1, d, SE_, ASA | ASB | SE);
        push(1, 0, d, SM, IOD | MW);
        push(0, 0, d, SM, 20'h0);
        push(1, 0, d, SF, MR);
        push(1, 0, d, SF, MR);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(e, s, c);
            n_cmp++;
            if (s !== e.st || c !== e.cw) begin
                n_err++;
                $display("FAIL sw_reset: state=%0d cw=%h required state=%0d cw=%h",
                         s, c, e.st, e.cw);
            end
        end
        n_cmp++;
        if (n_ret - r0 != 0) begin
            n_err++;
            $display("FAIL sw_reset_retire: retires=%0d required 0", n_ret - r0);
        end
    endtask

    task automatic test_trap;
        logic [31:0] d = 32'hFC000000;
        push(1, 1, d, SF, FET);
        push(1, 1, d, SD, 20'h0);
        for (int i = 0; i < 10; i++) push(1, 1, d, ST, ILL);
        push(0, 1, d, ST, 20'h0);
        push(1, 0, d, SF, MR);
        d = 32'h0000003F;
        push(1, 1, d, SF, FET);
        push(1, 1, d, SD, 20'h0);
        push(1, 1, d, ST, ILL);
        push(0, 0, d, ST, 20'h0);
        push(1, 0, d, SF, MR);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(e, s, c);
            n_cmp++;
            if (s !== e.st || c !== e.cw) begin
                n_err++;
                $display("FAIL trap: state=%0d cw=%h required state=%0d cw=%h",
                         s, c, e.st, e.cw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_lw_wait();
        test_back_to_back();
        test_sw_reset();
        test_trap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
